// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side
// hold/accept handshake. misalign exists only with IFETCH_MISALIGN_TRAP_EN.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_imm;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, misalign,
    input  imem_ready, imem_rdata, stall, branch_taken, branch_imm
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, misalign,
    output imem_ready, imem_rdata, stall, branch_taken, branch_imm
  );
`else
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ready, imem_rdata, stall, branch_taken, branch_imm
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ready, imem_rdata, stall, branch_taken, branch_imm
  );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: IDLE -> FETCH -> HOLD, redirect on accept.
// IFETCH_MISALIGN_TRAP_EN adds a sticky misalign flag and a TRAP state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_q, instr_pc_q;
  logic        load;
  logic [31:0] target;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign_q, set_misalign;
`endif

  assign target = instr_pc_q + bus.branch_imm;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    set_misalign = 1'b0;
`endif
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (bus.imem_ready) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          state_next = FETCH;
          if (bus.branch_taken) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
            pc_next = target;
            if (target[1:0] != 2'b00) begin
              state_next   = TRAP;
              set_misalign = 1'b1;
            end
`else
            pc_next = target & ~32'h0000_0003;
`endif
          end else begin
            pc_next = instr_pc_q + 32'd4;
          end
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      TRAP:    state_next = TRAP;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (load) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= pc;
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (set_misalign) misalign_q <= 1'b1;
`endif
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign bus.misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the fetch/hold/branch flow,
// plus hand sequences for trap/redirect and reset during an outstanding fetch.
module tb_instr_fetch;

  logic clk;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  assign bus.imem_rdata = mem(bus.imem_addr);

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] imm;
    logic        rdy;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic br, input logic [31:0] imm,
                              input logic rdy, input logic req, input logic valid,
                              input logic [31:0] addr, input logic [31:0] ipc);
    vec_t v;
    v.st = st; v.br = br; v.imm = imm; v.rdy = rdy;
    v.req = req; v.valid = valid; v.addr = addr; v.ipc = ipc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] imm, input logic rdy);
    bus.stall        = st;
    bus.branch_taken = br;
    bus.branch_imm   = imm;
    bus.imem_ready   = rdy;
  endtask

  task automatic cyc(input logic st, input logic br, input logic [31:0] imm, input logic rdy);
    @(negedge clk);
    drive(st, br, imm, rdy);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // state while reset is held, before any clock edge
    #3;
    chk("rst req",   {31'h0, bus.imem_req},    32'h0);
    chk("rst valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst instr", bus.instr,    32'h0000_0013);
    chk("rst ipc",   bus.instr_pc, 32'h0);
    chk("rst addr",  bus.imem_addr, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("rst misalign", {31'h0, bus.misalign}, 32'h0);
`endif

    //   st  br  imm           rdy  req valid addr          ipc
    add(0, 0, 32'h0,         0,   0,  0,   32'h0,        32'h0);        // IDLE
    add(0, 0, 32'h0,         1,   1,  0,   32'h0,        32'h0);
    add(0, 0, 32'h0,         1,   0,  1,   32'h0,        32'h0);        // ready ignored in HOLD
    add(0, 0, 32'h0,         1,   1,  0,   32'h4,        32'h0);
    add(0, 0, 32'h0,         0,   0,  1,   32'h0,        32'h4);
    add(0, 0, 32'h0,         1,   1,  0,   32'h8,        32'h0);
    add(0, 0, 32'h0,         0,   0,  1,   32'h0,        32'h8);
    add(0, 0, 32'h0,         1,   1,  0,   32'hC,        32'h0);
    for (int k = 0; k < 5; k++)
      add(1, 1, 32'h100,     1,   0,  1,   32'h0,        32'hC);        // stalled, branch ignored
    add(0, 0, 32'h0,         0,   0,  1,   32'h0,        32'hC);
    add(0, 0, 32'h0,         1,   1,  0,   32'h10,       32'h0);
    add(0, 1, 32'hFFFF_FFF8, 0,   0,  1,   32'h0,        32'h10);       // branch -8
    add(0, 1, 32'h40,        0,   1,  0,   32'h8,        32'h0);        // waiting on memory
    add(0, 0, 32'h0,         1,   1,  0,   32'h8,        32'h0);
    add(0, 0, 32'h0,         0,   0,  1,   32'h0,        32'h8);
    add(0, 0, 32'h0,         1,   1,  0,   32'hC,        32'h0);
    add(0, 0, 32'h0,         0,   0,  1,   32'h0,        32'hC);
    add(0, 0, 32'h0,         1,   1,  0,   32'h10,       32'h0);
    add(0, 1, 32'hFFFF_FFEC, 0,   0,  1,   32'h0,        32'h10);       // branch to top of space
    add(0, 0, 32'h0,         1,   1,  0,   32'hFFFF_FFFC, 32'h0);
    add(0, 0, 32'h0,         0,   0,  1,   32'h0,        32'hFFFF_FFFC); // +4 wraps
    add(0, 0, 32'h0,         1,   1,  0,   32'h0,        32'h0);
    add(0, 1, 32'h6,         0,   0,  1,   32'h0,        32'h0);        // misaligned target

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].st, vecs[i].br, vecs[i].imm, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d req", i),   {31'h0, bus.imem_req},    {31'h0, vecs[i].req});
      chk($sformatf("v%0d valid", i), {31'h0, bus.instr_valid}, {31'h0, vecs[i].valid});
      if (vecs[i].req)
        chk($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].addr);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d ipc", i),   bus.instr_pc, vecs[i].ipc);
        chk($sformatf("v%0d instr", i), bus.instr,    mem(vecs[i].ipc));
      end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 32'h0, 1);
      chk("trap misalign", {31'h0, bus.misalign},    32'h1);
      chk("trap req",      {31'h0, bus.imem_req},    32'h0);
      chk("trap valid",    {31'h0, bus.instr_valid}, 32'h0);
    end
`else
    cyc(0, 0, 32'h0, 0);
    chk("align req",  {31'h0, bus.imem_req}, 32'h1);
    chk("align addr", bus.imem_addr, 32'h4);
`endif

    // reset in the middle of an outstanding fetch
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0);
    #1;
    chk("r2 idle req", {31'h0, bus.imem_req}, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("r2 misalign", {31'h0, bus.misalign}, 32'h0);
`endif
    cyc(0, 0, 32'h0, 1);
    chk("r2 fetch0", bus.imem_addr, 32'h0);
    cyc(0, 0, 32'h0, 0);
    chk("r2 hold0 ipc", bus.instr_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 32'h0, 0);
      chk("r2 wait req",  {31'h0, bus.imem_req}, 32'h1);
      chk("r2 wait addr", bus.imem_addr, 32'h4);
    end
    #2;
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    #1;
    chk("async req",   {31'h0, bus.imem_req}, 32'h0);
    chk("async addr",  bus.imem_addr, 32'h0);
    chk("async instr", bus.instr, 32'h0000_0013);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stale req",   {31'h0, bus.imem_req},    32'h0);
    chk("stale valid", {31'h0, bus.instr_valid}, 32'h0);
    cyc(0, 0, 32'h0, 1);
    chk("refetch req",  {31'h0, bus.imem_req}, 32'h1);
    chk("refetch addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 32'h0, 0);
    chk("refetch valid", {31'h0, bus.instr_valid}, 32'h1);
    chk("refetch ipc",   bus.instr_pc, 32'h0);
    chk("refetch instr", bus.instr, mem(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
